// File: rtl/wash_sequencer.sv
// Run-phase controller: walks the eight timed wash phases of a latched
// program word, counting down on a 1 Hz tick, and drives valves and motor.
module wash_sequencer #(
   parameter int TW  = 4,
   parameter int TTW = 7
) (
   input  logic           cp,
   input  logic           rst_n,
   input  logic           tick,
   input  logic           start,
   input  logic           pauseBtn,
   input  logic           abort,
   input  logic           lidOpen,
   input  logic [25:0]    prog_word,
   output logic [2:0]     phase,
   output logic [TW-1:0]  remain,
   output logic [TTW-1:0] totalRemain,
   output logic           inValve,
   output logic           drainValve,
   output logic [1:0]     motor,
   output logic [2:0]     runState,
   output logic           done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      PAUSE = 3'd2,
      ERR   = 3'd3,
      DONE  = 3'd4
   } st_t;

   st_t            st, st_n;
   logic [2:0]     ph, ph_n;
   logic [TW-1:0]  rm, rm_n;
   logic [TTW-1:0] tt, tt_n;
   logic [25:0]    sh, sh_n;
   logic [3:0]     nx;

   function automatic logic [3:0] fld(
      input logic [25:0] p,
      input logic [2:0]  i
   );
      logic [3:0] f;
      case (i)
         3'd0:    f = {1'b0, p[25:23]};
         3'd1:    f = p[22:19];
         3'd2:    f = {1'b0, p[18:16]};
         3'd3:    f = {1'b0, p[15:13]};
         3'd4:    f = {1'b0, p[12:10]};
         3'd5:    f = p[9:6];
         3'd6:    f = {1'b0, p[5:3]};
         default: f = {1'b0, p[2:0]};
      endcase
      return f;
   endfunction

   // Lowest nonzero phase at or above 'from'; bit 3 set means none left.
   function automatic logic [3:0] nxt(
      input logic [25:0] p,
      input logic [3:0]  from
   );
      logic [3:0] r;
      r = 4'b1000;
      for (int i = 7; i >= 0; i--) begin
         if (i >= int'(from) && fld(p, 3'(i)) != 4'd0)
            r = {1'b0, 3'(i)};
      end
      return r;
   endfunction

   function automatic logic [TTW-1:0] sum(
      input logic [25:0] p
   );
      logic [TTW-1:0] s;
      s = '0;
      for (int i = 0; i < 8; i++)
         s = s + TTW'(fld(p, 3'(i)));
      return s;
   endfunction

   always_ff @(posedge cp or negedge rst_n) begin
      if (!rst_n) begin
         st <= IDLE;
         ph <= '0;
         rm <= '0;
         tt <= '0;
         sh <= '0;
      end else begin
         st <= st_n;
         ph <= ph_n;
         rm <= rm_n;
         tt <= tt_n;
         sh <= sh_n;
      end
   end

   always_comb begin
      st_n = st;
      ph_n = ph;
      rm_n = rm;
      tt_n = tt;
      sh_n = sh;
      nx   = 4'b1000;
      if (abort) begin
         st_n = IDLE;
         ph_n = '0;
         rm_n = '0;
         tt_n = '0;
      end else begin
         case (st)
            IDLE, DONE: begin
               if (start) begin
                  sh_n = prog_word;
                  nx   = nxt(prog_word, 4'd0);
                  if (nx[3]) begin
                     st_n = DONE;
                     ph_n = '0;
                     rm_n = '0;
                     tt_n = '0;
                  end else begin
                     st_n = RUN;
                     ph_n = nx[2:0];
                     rm_n = TW'(fld(prog_word, nx[2:0]));
                     tt_n = sum(prog_word);
                  end
               end
            end
            RUN: begin
               if (lidOpen) begin
                  st_n = ERR;
               end else if (pauseBtn) begin
                  st_n = PAUSE;
               end else if (tick) begin
                  tt_n = tt - TTW'(1);
                  if (rm > TW'(1)) begin
                     rm_n = rm - TW'(1);
                  end else begin
                     // zero-length phases are skipped in this same cycle
                     nx = nxt(sh, {1'b0, ph} + 4'd1);
                     if (nx[3]) begin
                        st_n = DONE;
                        rm_n = '0;
                        tt_n = '0;
                     end else begin
                        ph_n = nx[2:0];
                        rm_n = TW'(fld(sh, nx[2:0]));
                     end
                  end
               end
            end
            PAUSE: begin
               if (lidOpen)
                  st_n = ERR;
               else if (pauseBtn)
                  st_n = RUN;
            end
            ERR: begin
               if (!lidOpen)
                  st_n = PAUSE;
            end
            default: st_n = IDLE;
         endcase
      end
   end

   always_comb begin
      phase       = ph;
      remain      = rm;
      totalRemain = tt;
      runState    = st;
      done        = (st == DONE);
      inValve     = 1'b0;
      drainValve  = 1'b0;
      motor       = 2'b00;
      if (st == RUN) begin
         inValve    = (ph == 3'd0) || (ph == 3'd4);
         drainValve = (ph == 3'd2) || (ph == 3'd3) ||
                      (ph == 3'd6) || (ph == 3'd7);
         unique case (1'b1)
            (ph == 3'd1) || (ph == 3'd5): motor = 2'b01;
            (ph == 3'd3) || (ph == 3'd7): motor = 2'b10;
            default:                      motor = 2'b00;
         endcase
      end
   end

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: a time-elapsed reference model
// predicts every cycle's outputs; a monitor compares them.
module tb_wash_sequencer;

   logic        cp = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0, start = 1'b0, pauseBtn = 1'b0;
   logic        abort = 1'b0, lidOpen = 1'b0;
   logic [25:0] prog_word = '0;
   logic [2:0]  phase;
   logic [3:0]  remain;
   logic [6:0]  totalRemain;
   logic        inValve, drainValve, done;
   logic [1:0]  motor;
   logic [2:0]  runState;

   wash_sequencer #(.TW(4), .TTW(7)) dut (
      .cp(cp), .rst_n(rst_n), .tick(tick), .start(start),
      .pauseBtn(pauseBtn), .abort(abort), .lidOpen(lidOpen),
      .prog_word(prog_word), .phase(phase), .remain(remain),
      .totalRemain(totalRemain), .inValve(inValve),
      .drainValve(drainValve), .motor(motor),
      .runState(runState), .done(done)
   );

   always #5 cp = ~cp;

   int cyc = 0;
   always @(posedge cp) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int due;
      int ph;
      bit cph;
      int rm, tt, iv, dv, mo, rs, dn;
   } exp_t;
   exp_t sb[$];

   // model: phase durations, total length and elapsed ticks
   int md[8];
   int mT = 0, me = 0, mst = 0;
   int wid[8] = '{3, 4, 3, 3, 3, 4, 3, 3};
   int inl[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
   int drn[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
   int mot[8] = '{0, 1, 0, 2, 0, 1, 0, 2};

   function automatic void load(input logic [25:0] pw);
      int pos = 26;
      mT = 0;
      for (int i = 0; i < 8; i++) begin
         pos -= wid[i];
         md[i] = int'((pw >> pos) & ((26'd1 << wid[i]) - 26'd1));
         mT += md[i];
      end
      me = 0;
   endfunction

   function automatic exp_t predict();
      exp_t e;
      int c = 0;
      bit f = 0;
      e = '{default: 0};
      e.cph = 1;
      e.rs = mst;
      if (mst >= 1 && mst <= 3) begin
         for (int i = 0; i < 8; i++) begin
            if (!f && md[i] > 0 && c + md[i] > me) begin
               e.ph = i;
               e.rm = c + md[i] - me;
               f = 1;
            end
            c += md[i];
         end
         e.tt = mT - me;
         if (mst == 1) begin
            e.iv = inl[e.ph];
            e.dv = drn[e.ph];
            e.mo = mot[e.ph];
         end
      end
      if (mst == 4) begin
         e.cph = 0;
         e.dn = 1;
      end
      return e;
   endfunction

   function automatic void step(input bit ab, lid, pb, st, tk,
                                input logic [25:0] pw);
      if (ab) mst = 0;
      else case (mst)
         0, 4: if (st) begin
            load(pw);
            mst = (mT == 0) ? 4 : 1;
         end
         1: if (lid) mst = 3;
            else if (pb) mst = 2;
            else if (tk) begin
               me++;
               if (me == mT) mst = 4;
            end
         2: if (lid) mst = 3;
            else if (pb) mst = 1;
         3: if (!lid) mst = 2;
         default: mst = 0;
      endcase
   endfunction

   task automatic drv(input bit ab, lid, pb, st, tk,
                      input logic [25:0] pw);
      exp_t e;
      @(posedge cp);
      #1;
      abort = ab; lidOpen = lid; pauseBtn = pb;
      start = st; tick = tk; prog_word = pw;
      step(ab, lid, pb, st, tk, pw);
      e = predict();
      e.due = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic nop();
      drv(0, 0, 0, 0, 0, 26'd0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 1, 26'd0);
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge cp);
         #3;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n_chk++;
            if ((e.cph && int'(phase) != e.ph) ||
                int'(remain) != e.rm || int'(totalRemain) != e.tt ||
                int'(inValve) != e.iv || int'(drainValve) != e.dv ||
                int'(motor) != e.mo || int'(runState) != e.rs ||
                int'(done) != e.dn) begin
               n_fail++;
               $display("FAIL sb cyc%0d: got ph%0d rm%0d tt%0d iv%0d dv%0d mo%0d rs%0d dn%0d, expected ph%0d rm%0d tt%0d iv%0d dv%0d mo%0d rs%0d dn%0d",
                  cyc, phase, remain, totalRemain, inValve, drainValve,
                  motor, runState, done, e.ph, e.rm, e.tt, e.iv, e.dv,
                  e.mo, e.rs, e.dn);
            end
         end
      end
   end

   localparam logic [25:0] FULL = 26'b011_1010_100_101_011_1000_100_101;
   localparam logic [25:0] RINS = 26'b000_0000_100_101_011_1000_000_000;

   initial begin : stim
      bit lid = 0;
      int r;
      repeat (3) @(posedge cp);
      #2;
      chk("rst_state", int'(runState), 0);
      chk("rst_total", int'(totalRemain), 0);
      chk("rst_act", int'({inValve, drainValve, motor, done}), 0);
      @(negedge cp);
      rst_n = 1'b1;

      // full program
      drv(0, 0, 0, 1, 0, FULL); nop();
      chk("full_total", int'(totalRemain), 42);
      chk("full_remain", int'(remain), 3);
      ticks(41); nop();
      chk("full_not_done", int'(done), 0);
      ticks(1); nop();
      chk("full_done", int'(done), 1);
      chk("full_rs", int'(runState), 4);

      // rinse-only program, skipped phases
      drv(0, 0, 0, 1, 0, RINS); nop();
      chk("skip_phase", int'(phase), 2);
      chk("skip_remain", int'(remain), 4);
      chk("skip_total", int'(totalRemain), 20);
      ticks(4); nop();
      chk("skip_phase3", int'(phase), 3);
      chk("skip_drain", int'(drainValve), 1);
      chk("skip_motor", int'(motor), 2);
      ticks(16); nop();
      chk("skip_done", int'(runState), 4);

      // pause colliding with tick in WASH
      drv(0, 0, 0, 1, 0, FULL);
      ticks(6);
      drv(0, 0, 1, 0, 1, 26'd0); nop();
      chk("pause_rs", int'(runState), 2);
      chk("pause_remain", int'(remain), 7);
      chk("pause_motor", int'(motor), 0);
      ticks(5); nop();
      chk("pause_hold", int'(remain), 7);
      drv(0, 0, 1, 0, 0, 26'd0);
      ticks(1); nop();
      chk("resume_remain", int'(remain), 6);

      // lid error in SPIN_R
      ticks(10); nop();
      chk("spin_phase", int'(phase), 3);
      drv(0, 1, 0, 0, 0, 26'd0);
      drv(0, 1, 0, 0, 0, 26'd0);
      chk("err_rs", int'(runState), 3);
      chk("err_act", int'({inValve, drainValve, motor}), 0);
      for (int i = 0; i < 3; i++) drv(0, 1, 0, 0, 1, 26'd0);
      chk("err_hold", int'(remain), 5);
      nop(); nop();
      chk("err_to_pause", int'(runState), 2);
      drv(0, 0, 1, 0, 0, 26'd0); nop();
      chk("err_resume", int'(runState), 1);
      chk("err_total", int'(totalRemain), 42 - 17);

      // start ignored in RUN, abort, zero program
      drv(0, 0, 0, 1, 0, RINS); nop();
      chk("run_start_ign", int'(totalRemain), 25);
      drv(1, 0, 0, 0, 0, 26'd0); nop();
      chk("abort_rs", int'(runState), 0);
      chk("abort_total", int'(totalRemain), 0);
      drv(0, 0, 0, 1, 0, 26'd0); nop();
      chk("zero_done", int'(done), 1);
      chk("zero_total", int'(totalRemain), 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 99) < 2) lid = !lid;
         drv(r < 1, lid, r >= 1 && r < 4, r >= 4 && r < 8,
             1'($urandom_range(0, 1)), 26'($urandom));
      end
      nop(); nop();

      // async reset mid-run
      drv(0, 0, 0, 1, 0, FULL);
      ticks(5);
      @(posedge cp);
      #5;
      rst_n = 1'b0;
      #1;
      chk("arst_rs", int'(runState), 0);
      chk("arst_out", int'({phase, remain, totalRemain}), 0);
      chk("arst_act", int'({inValve, drainValve, motor, done}), 0);
      mst = 0;
      @(posedge cp);
      @(negedge cp);
      rst_n = 1'b1;
      nop(); nop();
      repeat (2) @(posedge cp);
      #4;
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
